// File: rtl/popcnt_rr_arbiter.sv
// Round-robin arbiter sharing one population-count datapath among NUM_REQ requesters.
// A one-entry result register lets the output drain and refill on the same edge.
module popcnt_rr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned IDW       = $clog2(NUM_REQ),
  parameter int unsigned CW        = $clog2(DATAWIDTH) + 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_ReqValid,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   i_ReqData,
  output logic [NUM_REQ-1:0]             o_ReqReady,
  output logic                           o_ResValid,
  output logic [IDW-1:0]                 o_ResId,
  output logic [CW-1:0]                  o_ResOnes,
  input  logic                           i_ResReady
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [CW-1:0]  res_ones_q, res_ones_d;

  logic                 can_accept;
  logic                 accept;
  logic                 grant_found;
  logic [IDW-1:0]       grant_idx;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic [DATAWIDTH-1:0] grant_word;
  int unsigned          scan_idx;

  function automatic logic [CW-1:0] popcount(input logic [DATAWIDTH-1:0] word);
    logic [CW-1:0] sum;
    sum = '0;
    for (int unsigned b = 0; b < DATAWIDTH; b++) begin
      sum = sum + CW'(word[b]);
    end
    return sum;
  endfunction

  // Scan from the pointer upward, wrapping, and take the first valid requester.
  always_comb begin
    grant_found  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    grant_word   = '0;
    scan_idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!grant_found && i_ReqValid[scan_idx]) begin
        grant_found            = 1'b1;
        grant_idx              = IDW'(scan_idx);
        grant_onehot[scan_idx] = 1'b1;
        grant_word             = i_ReqData[scan_idx*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign can_accept = (state_q == StEmpty) || i_ResReady;
  assign accept     = can_accept && grant_found && !i_rst;
  assign o_ReqReady = accept ? grant_onehot : '0;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    res_id_d   = res_id_q;
    res_ones_d = res_ones_q;
    if (accept) begin
      state_d    = StFull;
      res_id_d   = grant_idx;
      res_ones_d = popcount(grant_word);
      ptr_d      = IDW'((32'(grant_idx) + 1) % NUM_REQ);
    end else if (state_q == StFull && i_ResReady) begin
      // Drain only; id/ones keep their last values.
      state_d = StEmpty;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StEmpty;
      ptr_q      <= '0;
      res_id_q   <= '0;
      res_ones_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      res_id_q   <= res_id_d;
      res_ones_q <= res_ones_d;
    end
  end

  assign o_ResValid = (state_q == StFull);
  assign o_ResId    = res_id_q;
  assign o_ResOnes  = res_ones_q;

endmodule

// File: tb/tb_popcnt_rr_arbiter.sv
// Self-checking bench for popcnt_rr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_popcnt_rr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [4:0]     res_ones;
  logic           res_ready;

  int n_cmp;
  int n_fail;

  // Reference model state: held result and round-robin pointer.
  bit m_full;
  int m_id;
  int m_ones;
  int m_ptr;

  popcnt_rr_arbiter #(
    .NUM_REQ  (N),
    .DATAWIDTH(W)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_ReqValid(req_valid),
    .i_ReqData (req_data),
    .o_ReqReady(req_ready),
    .o_ResValid(res_valid),
    .o_ResId   (res_id),
    .o_ResOnes (res_ones),
    .i_ResReady(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_pick();
    if (rst) return -1;
    if (m_full && !res_ready) return -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_grant();
    int k;
    logic [N-1:0] g;
    k = model_pick();
    g = '0;
    if (k >= 0) g[k] = 1'b1;
    return g;
  endfunction

  task automatic model_update();
    int k;
    if (rst) begin
      m_full = 0; m_id = 0; m_ones = 0; m_ptr = 0;
    end else begin
      k = model_pick();
      if (k >= 0) begin
        m_full = 1;
        m_id   = k;
        m_ones = $countones(req_data[k*W +: W]);
        m_ptr  = (k + 1) % N;
      end else if (m_full && res_ready) begin
        m_full = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_word(input int k, input logic [W-1:0] w);
    req_data[k*W +: W] = w;
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 4'b1111; res_ready = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ready cyc%0d: got %b want 0000", c, req_ready);
      end
      tick();
      n_cmp++;
      if ({res_valid, res_id, res_ones} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: got v=%b id=%0d ones=%0d want 0/0/0",
                 c, res_valid, res_id, res_ones);
      end
    end
    rst = 0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b want 0001", req_ready);
    end
    tick();
  endtask

  task automatic test_single();
    req_valid = '0; res_ready = 1;
    tick();
    req_valid = 4'b0100; set_word(2, 16'hBF1F);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_grant: got %b want 0100", req_ready);
    end
    tick();
    n_cmp++;
    if ({res_valid, res_id, res_ones} !== {1'b1, 2'd2, 5'd12}) begin
      n_fail++;
      $display("FAIL single_result: got v=%b id=%0d ones=%0d want 1/2/12",
               res_valid, res_id, res_ones);
    end
    req_valid = '0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle_ready: got %b want 0000", req_ready);
    end
    tick();
    n_cmp++;
    if ({res_valid, res_id, res_ones} !== {1'b0, 2'd2, 5'd12}) begin
      n_fail++;
      $display("FAIL single_drain: got v=%b id=%0d ones=%0d want 0/2/12",
               res_valid, res_id, res_ones);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] ones_tbl [N];
    ones_tbl = '{5'd1, 5'd10, 5'd16, 5'd15};
    rst = 1; req_valid = '0; res_ready = 1;
    tick();
    rst = 0;
    set_word(0, 16'h0001); set_word(1, 16'hF0AF); set_word(2, 16'hFFFF); set_word(3, 16'hFFFE);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      logic [N-1:0] eg;
      eg = '0;
      eg[c % N] = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== eg) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b want %b", c, req_ready, eg);
      end
      tick();
      n_cmp++;
      if ({res_valid, res_id, res_ones} !== {1'b1, 2'(c % N), ones_tbl[c % N]}) begin
        n_fail++;
        $display("FAIL rr_result%0d: got v=%b id=%0d ones=%0d want 1/%0d/%0d",
                 c, res_valid, res_id, res_ones, c % N, ones_tbl[c % N]);
      end
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0010; res_ready = 1;
    tick();
    req_valid = 4'b0001; res_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready);
      end
      tick();
      n_cmp++;
      if ({res_valid, res_id, res_ones} !== {1'b1, 2'd1, 5'd10}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d ones=%0d want 1/1/10",
                 c, res_valid, res_id, res_ones);
      end
    end
    res_ready = 1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_release_grant: got %b want 0001", req_ready);
    end
    tick();
    n_cmp++;
    if ({res_valid, res_id, res_ones} !== {1'b1, 2'd0, 5'd1}) begin
      n_fail++;
      $display("FAIL bp_release_result: got v=%b id=%0d ones=%0d want 1/0/1",
               res_valid, res_id, res_ones);
    end
  endtask

  task automatic test_pointer_hold();
    req_valid = '0; res_ready = 1;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    tick();
    req_valid = 4'b1001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL ptr_hold_first: got %b want 1000", req_ready);
    end
    tick();
    n_cmp++;
    if (req_ready !== 4'b0001 || res_id !== 2'd3) begin
      n_fail++;
      $display("FAIL ptr_hold_second: got grant=%b id=%0d want 0001/3", req_ready, res_id);
    end
    tick();
    n_cmp++;
    if (res_id !== 2'd0 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ptr_hold_result: got v=%b id=%0d want 1/0", res_valid, res_id);
    end
  endtask

  task automatic test_reset_midstream();
    req_valid = 4'b0100; res_ready = 1;
    tick();
    res_ready = 0; rst = 1; req_valid = 4'b1111;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b want 0000", req_ready);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_valid: got %b want 0", res_valid);
    end
    rst = 0; req_valid = 4'b1001; res_ready = 1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_first_grant: got %b want 0001", req_ready);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] eg;
      rst       = ($urandom_range(0, 59) == 0);
      req_valid = N'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 3))
          0:       set_word(k, '0);
          1:       set_word(k, '1);
          default: set_word(k, W'($urandom));
        endcase
      end
      eg = model_grant();
      #1;
      n_cmp++;
      if (req_ready !== eg) begin
        n_fail++;
        $display("FAIL rand_grant c%0d: got %b want %b", c, req_ready, eg);
      end
      tick();
      n_cmp++;
      if ({res_valid, res_id, res_ones} !== {m_full, 2'(m_id), 5'(m_ones)}) begin
        n_fail++;
        $display("FAIL rand_result c%0d: got v=%b id=%0d ones=%0d want %0d/%0d/%0d",
                 c, res_valid, res_id, res_ones, m_full, m_id, m_ones);
      end
    end
    rst = 0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_full = 0; m_id = 0; m_ones = 0; m_ptr = 0;
    rst = 1; req_valid = '0; req_data = '0; res_ready = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pointer_hold();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/popcnt_rr_arbiter.md
Name: popcnt_rr_arbiter

Overview:
- Shares a single DATAWIDTH-bit ones-counter datapath among NUM_REQ requesters.
- Arbitration is round-robin.
- Each accepted word produces one registered result carrying the population count and the ID of the requester that sent it.
- Sits between several producer blocks and one downstream consumer. Valid/ready handshake on every side.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATAWIDTH, 16, bits per request word.
- IDW, $clog2(NUM_REQ), derived, requester ID width.
- CW, $clog2(DATAWIDTH)+1, derived, count width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset.
- i_ReqValid  in  NUM_REQ  bit k = requester k presents a word.
- i_ReqData  in  NUM_REQ*DATAWIDTH  requester k word in bits [k*DATAWIDTH +: DATAWIDTH].
- o_ReqReady  out  NUM_REQ  one-hot grant; bit k high = requester k's word is accepted this cycle.
- o_ResValid  out  1  result register holds a valid result.
- o_ResId  out  IDW  requester ID of the held result.
- o_ResOnes  out  CW  number of ones in the accepted word (0..DATAWIDTH).
- i_ResReady  in  1  consumer takes the result when high together with o_ResValid.

Interface: one clock; reset is synchronous and active-high (i_clk, i_rst).

Behaviour:
- Reset, sampled on i_clk edge: o_ResValid=0, o_ResId=0, o_ResOnes=0, priority pointer=0 (requester 0 highest), FSM=EMPTY. o_ReqReady is all-zero while i_rst=1.
- FSM: EMPTY (no result held) and FULL (result held).
- Accept condition: can_accept = (state==EMPTY) or (state==FULL and i_ResReady).
- Grant selection:
  - When can_accept and any i_ReqValid is set, grant the first valid requester scanning ptr, ptr+1, … modulo NUM_REQ.
  - o_ReqReady is the one-hot of that requester.
  - o_ReqReady is combinational from i_ReqValid, the pointer and the state.
  - o_ReqReady is zero when can_accept=0 or no request is valid.
  - Requesters must not make valid depend on ready.
- On accept, at the clock edge:
  - o_ResOnes <= popcount of the granted word, computed as a zero-extended CW-bit sum of its bits.
  - o_ResId <= granted index.
  - o_ResValid <= 1.
  - ptr <= (granted+1) mod NUM_REQ.
  - FSM goes to FULL.
- Latency: a word accepted at edge N gives o_ResValid=1 with its result after edge N, i.e. one cycle.
- Drain without accept: FULL, i_ResReady=1, no valid request → o_ResValid <= 0, FSM goes to EMPTY. o_ResId and o_ResOnes hold their last values.
- Simultaneous drain and accept: FULL, i_ResReady=1, a request valid → the new result replaces the old one in the same edge. o_ResValid stays 1, giving full throughput of one word per cycle.
- Backpressure: FULL and i_ResReady=0 → result outputs are stable, o_ReqReady=0, pointer unchanged.
- Pointer changes only on an accept. An idle cycle does not advance it.
- Fairness: with all requesters continuously valid and no backpressure, the grant order is 0,1,…,NUM_REQ-1,0,… Each requester waits at most NUM_REQ-1 grants.
- Arithmetic: all-ones word → o_ResOnes=DATAWIDTH, e.g. 16 = 5'b10000. No overflow is possible.
- Reset mid-operation: any held result is discarded, o_ResValid=0 in the next cycle, pointer returns to 0. An accept in the reset cycle is ignored.
- When NUM_REQ is not a power of two, IDs NUM_REQ..2^IDW-1 never appear.

Test Plan (NUM_REQ=4, DATAWIDTH=16):
- Reset: hold i_rst 2 cycles with all i_ReqValid=1 → o_ReqReady=0000, o_ResValid=0, o_ResId=0, o_ResOnes=0. After release, the first grant is 0001.
- Single requester: req2 valid with 16'hBF1F, i_ResReady=1 → o_ReqReady=0100 for one cycle. Next cycle o_ResValid=1, o_ResId=2, o_ResOnes=12. Then o_ResValid=0.
- Round-robin: all four valid, words 16'h0001, 16'hF0AF, 16'hFFFF, 16'hFFFE, i_ResReady=1 → grants 0001, 0010, 0100, 1000, 0001. Results (ID, ones) = (0,1), (1,10), (2,16), (3,15), back-to-back, one per cycle.
- Backpressure: result (ID 1, ones 10) held with i_ResReady=0 for 3 cycles and req0 valid → o_ReqReady=0000 and outputs stable all 3 cycles. On the i_ResReady=1 cycle, req0 is granted, and the next cycle shows (ID 0).
- Pointer hold: grant req1, then an idle cycle, then req0 and req3 valid together → req3 granted first (pointer=2), then req0.
- Reset mid-stream: assert i_rst while FULL with i_ResReady=0 → o_ResValid=0 the next cycle. After release, with req3 and req0 valid, req0 is granted first.
